// File: rtl/sum_fact_host_if.sv
// Request/response link between the sweep host and one sum_fact_N.
// The host drives N_out/input_valid/output_ack; the responder returns results.
interface sum_fact_host_if;
    logic [2:0]  N_out;
    logic        input_valid;
    logic [12:0] sum_fact;
    logic        output_valid;
    logic        output_ack;

    modport master (
        output N_out,
        output input_valid,
        output output_ack,
        input  sum_fact,
        input  output_valid
    );

    modport slave (
        input  N_out,
        input  input_valid,
        input  output_ack,
        output sum_fact,
        output output_valid
    );
endinterface

// File: rtl/sum_fact_host.sv
// Sweep sequencer: issues N over a wrapping 3-bit range, checks each result
// against the sum-of-factorials table and runs a four-phase ack per result.
module sum_fact_host #(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [2:0]       i_n_first,
    input  logic [2:0]       i_n_last,
    sum_fact_host_if.master  bus,
    output logic             o_busy,
    output logic             o_done,
    output logic [12:0]      o_last_result,
    output logic [3:0]       o_err_count,
    output logic             o_timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT);

    state_t      r_state;
    logic [2:0]  r_n_cur;
    logic [2:0]  r_n_end;
    logic [2:0]  r_n_out;
    logic        r_in_valid;
    logic        r_ack;
    logic        r_busy;
    logic        r_done;
    logic        r_to_err;
    logic [12:0] r_last;
    logic [3:0]  r_err;
    logic [7:0]  r_timer;

    logic [7:0]  w_timer_nxt;
    logic        w_expired;
    logic [12:0] w_gold;
    logic        w_mismatch;
    logic        w_err_sat;

    // Sum of k! for k = 1..n, indexed by the 3-bit N.
    function automatic logic [12:0] golden(input logic [2:0] n);
        logic [12:0] g;
        unique case (n)
            3'd0: g = 13'd0;
            3'd1: g = 13'd1;
            3'd2: g = 13'd3;
            3'd3: g = 13'd9;
            3'd4: g = 13'd33;
            3'd5: g = 13'd153;
            3'd6: g = 13'd873;
            3'd7: g = 13'd5913;
            default: g = 13'd0;
        endcase
        return g;
    endfunction

    // The timer counts the cycle being completed, so expiry is judged on
    // its next value: exactly TIMEOUT cycles are spent in WAIT or ACK.
    assign w_timer_nxt = r_timer + 8'd1;
    assign w_expired   = (w_timer_nxt == TMAX);
    assign w_gold      = golden(r_n_cur);
    assign w_mismatch  = (bus.sum_fact != w_gold);
    assign w_err_sat   = (r_err == 4'hF);

    assign bus.N_out       = r_n_out;
    assign bus.input_valid = r_in_valid;
    assign bus.output_ack  = r_ack;

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_last_result = r_last;
    assign o_err_count   = r_err;
    assign o_timeout_err = r_to_err;

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_n_cur    <= 3'd0;
            r_n_end    <= 3'd0;
            r_n_out    <= 3'd0;
            r_in_valid <= 1'b0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_to_err   <= 1'b0;
            r_last     <= 13'd0;
            r_err      <= 4'd0;
            r_timer    <= 8'd0;
        end else begin
            r_in_valid <= 1'b0;
            r_done     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_n_cur  <= i_n_first;
                        r_n_end  <= i_n_last;
                        r_err    <= 4'd0;
                        r_to_err <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_n_out    <= r_n_cur;
                    r_in_valid <= 1'b1;
                    r_timer    <= 8'd0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.output_valid) begin
                        r_last  <= bus.sum_fact;
                        if (w_mismatch && !w_err_sat) begin
                            r_err <= r_err + 4'd1;
                        end
                        r_timer <= 8'd0;
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end else if (w_expired) begin
                        r_to_err <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_timer <= w_timer_nxt;
                    end
                end
                S_ACK: begin
                    // Ack stays high through this edge and drops in NEXT.
                    if (!bus.output_valid) begin
                        r_state <= S_NEXT;
                    end else if (w_expired) begin
                        r_ack    <= 1'b0;
                        r_to_err <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_timer <= w_timer_nxt;
                    end
                end
                S_NEXT: begin
                    r_ack <= 1'b0;
                    if (r_n_cur == r_n_end) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_n_cur <= r_n_cur + 3'd1;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_fact_host.sv
// Randomized scoreboard bench for sum_fact_host with a behavioural responder.
// Expected issues, captures and sweep endings are queued; a monitor checks them.
module tb_sum_fact_host;

    localparam int TO = 16;

    typedef struct packed {
        logic [12:0] last;
        logic [3:0]  err;
        logic        to;
    } end_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [2:0]  i_n_first = 3'd0;
    logic [2:0]  i_n_last = 3'd0;
    logic        o_busy;
    logic        o_done;
    logic [12:0] o_last_result;
    logic [3:0]  o_err_count;
    logic        o_timeout_err;

    sum_fact_host_if ifc ();

    sum_fact_host #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_n_first     (i_n_first),
        .i_n_last      (i_n_last),
        .bus           (ifc),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_last_result (o_last_result),
        .o_err_count   (o_err_count),
        .o_timeout_err (o_timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;

    int   q_n[$];
    int   q_cap[$];
    end_t q_end[$];

    int m_last = 0;
    int r_mode = 0;
    int lat_fix = 0;
    int rel_fix = 0;
    bit bad_en[8];
    int bad_val[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int gold(input int n);
        int s = 0;
        int f = 1;
        for (int k = 1; k <= n; k++) begin
            f = f * k;
            s = s + f;
        end
        return s;
    endfunction

    function automatic int resp(input int n);
        return bad_en[n] ? bad_val[n] : gold(n);
    endfunction

    // Behavioural sum_fact_N: mode 0 normal, 1 silent, 2 holds valid after ack.
    initial begin
        int n, lat, rel;
        ifc.sum_fact = 13'd0;
        ifc.output_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.input_valid && r_mode != 1) begin
                n = int'(ifc.N_out);
                lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 6));
                rel = (rel_fix != 0) ? rel_fix : int'($urandom_range(1, 3));
                repeat (lat) @(negedge clk);
                ifc.sum_fact = 13'(resp(n));
                ifc.output_valid = 1'b1;
                for (int i = 0; i < 40 && !ifc.output_ack; i++) @(negedge clk);
                if (r_mode == 2) begin
                    for (int i = 0; i < 200 && r_mode == 2; i++) @(negedge clk);
                end else begin
                    repeat (rel) @(negedge clk);
                end
                ifc.output_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    bit pv_iv = 1'b0;
    bit pv_ack = 1'b0;
    bit pv_done = 1'b0;
    always @(negedge clk) begin
        end_t e;
        if (reset) begin
            pv_iv = 1'b0;
            pv_ack = 1'b0;
            pv_done = 1'b0;
        end else begin
            if (ifc.input_valid) begin
                chk("iv_pulse_width", int'(pv_iv), 0);
                if (q_n.size() == 0) begin
                    chk("issue_unexpected", int'(ifc.N_out), -1);
                end else begin
                    chk("issue_N", int'(ifc.N_out), q_n.pop_front());
                end
            end
            if (ifc.output_ack && !pv_ack) begin
                if (q_cap.size() == 0) begin
                    chk("capture_unexpected", int'(o_last_result), -1);
                end else begin
                    chk("capture_value", int'(o_last_result), q_cap.pop_front());
                end
            end
            if (o_done) begin
                done_cnt++;
                chk("done_pulse_width", int'(pv_done), 0);
                if (q_end.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = q_end.pop_front();
                    chk("end_last_result", int'(o_last_result), int'(e.last));
                    chk("end_err_count", int'(o_err_count), int'(e.err));
                    chk("end_timeout_err", int'(o_timeout_err), int'(e.to));
                end
            end
            pv_iv = ifc.input_valid;
            pv_ack = ifc.output_ack;
            pv_done = o_done;
        end
    end

    // kind: 0 normal, 1 responder silent, 2 responder holds valid.
    task automatic run_sweep(input int f, input int l, input int kind);
        int cnt, lim, errs, n, v;
        end_t e;
        cnt = ((l - f) + 8) % 8 + 1;
        errs = 0;
        if (kind == 1) begin
            q_n.push_back(f);
        end else begin
            lim = (kind == 2) ? 1 : cnt;
            for (int k = 0; k < lim; k++) begin
                n = (f + k) % 8;
                q_n.push_back(n);
                v = resp(n);
                q_cap.push_back(v);
                if (v != gold(n)) errs++;
                m_last = v;
            end
        end
        e.last = 13'(m_last);
        e.err = 4'((errs > 15) ? 15 : errs);
        e.to = (kind != 0);
        q_end.push_back(e);
        r_mode = kind;
        @(negedge clk);
        i_start = 1'b1;
        i_n_first = 3'(f);
        i_n_last = 3'(l);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_iv(input int budget, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (ifc.input_valid) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        if (!seen) chk("issue_timeout", 0, 1);
    endtask

    task automatic clear_bad();
        for (int i = 0; i < 8; i++) begin
            bad_en[i] = 1'b0;
            bad_val[i] = 0;
        end
    endtask

    initial begin
        int c0, t0, t1, f, l, dc;
        clear_bad();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_iv", int'(ifc.input_valid), 0);
        chk("rst_ack", int'(ifc.output_ack), 0);
        chk("rst_last", int'(o_last_result), 0);
        chk("rst_err", int'(o_err_count), 0);
        chk("rst_to", int'(o_timeout_err), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single transaction 7..7, fixed latency 5 and release 1.
        lat_fix = 5;
        rel_fix = 1;
        run_sweep(7, 7, 0);
        c0 = cyc;
        wait_iv(20, t0);
        chk("issue_latency", t0 - c0, 1);
        wait_done(100, t1);
        @(negedge clk);
        chk("t1_busy_after", int'(o_busy), 0);
        chk("t1_last", int'(o_last_result), 5913);
        lat_fix = 0;
        rel_fix = 0;

        // Full sweep with a correct responder.
        run_sweep(0, 7, 0);
        wait_done(400, t1);

        // Two wrong answers.
        bad_en[3] = 1'b1;
        bad_val[3] = 10;
        bad_en[5] = 1'b1;
        bad_val[5] = 0;
        run_sweep(0, 7, 0);
        wait_done(400, t1);
        chk("t3_err_count", int'(o_err_count), 2);
        clear_bad();

        // Wrapping range.
        run_sweep(6, 1, 0);
        wait_done(400, t1);

        // Silent responder: WAIT timeout.
        run_sweep(4, 4, 1);
        wait_iv(20, t0);
        wait_done(100, t1);
        chk("wait_timeout_cycles", t1 - t0, TO);
        r_mode = 0;
        repeat (3) @(negedge clk);

        // Responder holds valid: ACK timeout must release ack.
        run_sweep(2, 4, 2);
        wait_done(200, t1);
        chk("ack_released", int'(ifc.output_ack), 0);
        repeat (2) @(negedge clk);
        r_mode = 0;
        repeat (5) @(negedge clk);

        // Start and range changes while busy are ignored.
        run_sweep(1, 3, 0);
        wait_iv(20, t0);
        i_start = 1'b1;
        i_n_first = 3'd6;
        i_n_last = 3'd6;
        repeat (3) @(negedge clk);
        i_start = 1'b0;
        wait_done(400, t1);
        @(negedge clk);
        chk("busy_start_idle", int'(o_busy), 0);

        // Random sweeps with random corruptions.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                bad_en[i] = ($urandom_range(0, 3) == 0);
                bad_val[i] = gold(i) ^ int'($urandom_range(1, 8191));
            end
            f = int'($urandom_range(0, 7));
            l = int'($urandom_range(0, 7));
            run_sweep(f, l, 0);
            wait_done(400, t1);
        end
        clear_bad();

        // Reset mid-WAIT with start held during reset.
        lat_fix = 10;
        run_sweep(0, 7, 0);
        wait_iv(20, t0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        i_start = 1'b1;
        q_n.delete();
        q_cap.delete();
        q_end.delete();
        m_last = 0;
        #1;
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_iv", int'(ifc.input_valid), 0);
        chk("mid_rst_ack", int'(ifc.output_ack), 0);
        chk("mid_rst_nout", int'(ifc.N_out), 0);
        chk("mid_rst_last", int'(o_last_result), 0);
        chk("mid_rst_done", int'(o_done), 0);
        @(negedge clk);
        reset = 1'b0;
        i_start = 1'b0;
        dc = done_cnt;
        repeat (60) @(negedge clk);
        chk("no_done_after_rst", done_cnt, dc);
        chk("late_result_ignored", int'(o_last_result), 0);
        chk("idle_after_rst", int'(o_busy), 0);
        lat_fix = 0;

        // Recovery sweep.
        run_sweep(5, 5, 0);
        wait_done(100, t1);
        repeat (3) @(negedge clk);

        chk("queues_drained", q_n.size() + q_cap.size() + q_end.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sum_fact_host.md
# sum_fact_host

Requester-side sequencer for the `sum_fact_N` handshake. On `start` it sweeps N over a programmed range and issues each N with a one-cycle `input_valid` pulse. For each N it waits for `output_valid`, captures and checks `sum_fact` against a built-in golden table, then completes a four-phase `output_ack` handshake. It sits between a control/test harness and one `sum_fact_N` instance, replacing hand-written stimulus.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles spent in WAIT or ACK before aborting. Range 1..255; the counter is 8 bits.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sweep. Sampled only in IDLE.
- `n_first` in 3: first N of the sweep. Sampled when `start` is accepted.
- `n_last` in 3: last N of the sweep. Sampled when `start` is accepted.
- `N_out` out 3: N driven to `N_in` of `sum_fact_N`.
- `input_valid` out 1: request strobe to `sum_fact_N`.
- `sum_fact` in 13: result from `sum_fact_N`.
- `output_valid` in 1: result-valid flag from `sum_fact_N`.
- `output_ack` out 1: result acknowledge to `sum_fact_N`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `last_result` out 13: most recently captured `sum_fact`.
- `err_count` out 4: number of mismatches in the current sweep. Saturates at 15.
- `timeout_err` out 1: sticky. Set on a timeout, cleared on reset or an accepted `start`.

## Operation
- Reset (asynchronous) forces all outputs to 0, the state to IDLE, and all internal registers to 0.
- Golden table: G(N) = sum of k! for k = 1..N. The values for N = 0..7 are 0, 1, 3, 9, 33, 153, 873, 5913.
- FSM states:
  - IDLE: `busy`=0. If `start`=1, latch `n_first` into `n_cur` and `n_last` into `n_end`, clear `err_count` and `timeout_err`, then go to ISSUE. Otherwise stay.
  - ISSUE: drive `N_out`=`n_cur` and `input_valid`=1 for exactly this one cycle. Clear the timer and go to WAIT. `N_out` holds `n_cur` until the next ISSUE.
  - WAIT: the timer increments every cycle.
    - If `output_valid`=1: capture `sum_fact` into `last_result`. If `sum_fact` ≠ G(`n_cur`), increment `err_count` (saturating). Clear the timer and go to ACK.
    - Else if the timer reaches `TIMEOUT`: set `timeout_err` and go to DONE.
  - ACK: `output_ack`=1.
    - When `output_valid`=0 is sampled, drop `output_ack` next cycle and go to NEXT.
    - If the timer reaches `TIMEOUT` first: set `timeout_err` and go to DONE. `output_ack` is deasserted on leaving ACK.
  - NEXT: if `n_cur`==`n_end`, go to DONE. Otherwise `n_cur` ← `n_cur`+1 (3-bit, so 7 wraps to 0) and go to ISSUE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Range rules:
  - `n_first`==`n_last` gives a single transaction.
  - `n_last` < `n_first` wraps: for example, 6..1 issues 6, 7, 0, 1.
  - `n_first`=0, `n_last`=7 gives 8 transactions. A full-circle sweep is not possible.
- `start` while `busy` is ignored. `n_first` and `n_last` changing mid-sweep have no effect.
- A `sum_fact` value arriving while not in WAIT is ignored. `last_result` changes only on a WAIT capture.
- Reset mid-sweep aborts immediately. Outputs go low in the same cycle; there is no `done` pulse.
- `last_result` and `err_count` hold after DONE until the next accepted `start`.

## Timing
- Let `start` be sampled high at edge 0.
  - `input_valid` is high between edges 1 and 2.
  - WAIT is entered at edge 2.
- If `output_valid` is first sampled high at edge k:
  - `last_result` and `err_count` update at edge k.
  - `output_ack` rises at edge k.
- If `output_valid` is first sampled low at edge m > k:
  - `output_ack` falls at edge m+1 (NEXT).
  - The next `input_valid` rises at edge m+2.
- Per-transaction overhead is 4 cycles plus DUT latency plus ack-release latency. Last NEXT → DONE takes 1 cycle, and `done` is high for one cycle.
- Timeout: exactly `TIMEOUT` cycles in WAIT or ACK without progress sets `timeout_err` on the transition edge into DONE.

## Test plan
- Behavioural responder with 5-cycle latency that drops valid 1 cycle after ack; sweep 7..7 → one `input_valid` pulse with `N_out`=7, `last_result`=5913, `err_count`=0, `done` pulse, `busy` low afterwards.
- Full sweep 0..7 with a correct responder → 8 transactions in order 0..7, final `last_result`=5913, `err_count`=0, `timeout_err`=0.
- Responder returns wrong values for N=3 (10) and N=5 (0) in a 0..7 sweep → `err_count`=2.
- Wrap sweep `n_first`=6, `n_last`=1 → `N_out` sequence 6, 7, 0, 1; captured values 873, 5913, 0, 1.
- Responder never asserts `output_valid`, with `TIMEOUT`=16 → `timeout_err`=1 and a `done` pulse exactly 16 cycles after WAIT entry. Separately, a responder that holds valid high after ack → timeout from ACK with `output_ack` released.
- `reset` pulsed mid-WAIT, plus `start` re-asserted while busy → outputs 0 immediately and no `done`; the second `start` has no effect until IDLE.
